// File: rtl/multi_bank_bram_ctrl_pkg.sv
// Shared constants and types for the multi-bank vertex-value BRAM front end.
// Memory geometry, the vertex address split and the controller state encoding.
package multi_bank_bram_ctrl_pkg;

    localparam int LINE_W     = 512;
    localparam int BANKS      = 64;
    localparam int BANK_SEL_W = 6;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/mbb_resp_fifo.sv
// Small synchronous FIFO with a combinational head, used to buffer BRAM read
// responses so the consumer can apply backpressure.
module mbb_resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_reg == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (count_reg != FULL_CNT);
    assign head    = mem_reg[rd_ptr_reg];
    assign count   = count_reg;

    // Entries are reset so the head reads as zero while the FIFO is empty after reset.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_reg[gi] <= '0;
                end else if (push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/multi_bank_bram_ctrl.sv
// Front end for the 64-bank vertex-value BRAM: arbitrates byte reads and line
// writes, tracks the 2-cycle read latency and runs the CLEAR_VAL fill sweep.
module multi_bank_bram_ctrl
    import multi_bank_bram_ctrl_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter int                ADDR_W     = 10,
    parameter int                RESP_DEPTH = 4,
    parameter logic [DATA_W-1:0] CLEAR_VAL  = 8'hFF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr_start,
    output logic                         clr_busy,
    output logic                         clr_done,
    input  logic                         rd_req_valid,
    output logic                         rd_req_ready,
    input  logic [ADDR_W+BANK_SEL_W-1:0] rd_req_addr,
    output logic                         rd_resp_valid,
    input  logic                         rd_resp_ready,
    output logic [DATA_W-1:0]            rd_resp_data,
    input  logic                         wr_req_valid,
    output logic                         wr_req_ready,
    input  logic [ADDR_W-1:0]            wr_req_addr,
    input  logic [LINE_W-1:0]            wr_req_data,
    output logic [LINE_W-1:0]            bram_data_in,
    output logic [ADDR_W+BANK_SEL_W-1:0] bram_r_addr,
    output logic [ADDR_W-1:0]            bram_w_addr,
    output logic                         bram_we,
    output logic                         bram_en,
    input  logic [DATA_W-1:0]            bram_data_out
);

    localparam int              CNT_W     = $clog2(RESP_DEPTH) + 1;
    localparam logic [CNT_W:0]  CREDITS   = (CNT_W+1)'(RESP_DEPTH);
    localparam logic [ADDR_W:0] LAST_LINE = {1'b0, {ADDR_W{1'b1}}};

    ctrl_state_e     state_reg, state_next;
    logic [ADDR_W:0] line_cnt_reg, line_cnt_next;
    logic            clr_done_reg, clr_done_next;
    logic            active_reg;
    logic [1:0]      vld_reg;

    logic [1:0]       inflight;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   used;
    logic             fifo_empty;
    logic             run_ok;
    logic             wr_accept;
    logic             rd_accept;
    logic             collision;
    logic             resp_pop;

    assign inflight = {1'b0, vld_reg[0]} + {1'b0, vld_reg[1]};
    assign used     = {1'b0, fifo_count} + (CNT_W+1)'(inflight);

    // active_reg keeps every ready and the memory enable low until the first edge after reset.
    assign run_ok       = active_reg & (state_reg == RUN);
    assign wr_req_ready = run_ok;
    assign wr_accept    = wr_req_valid & run_ok;
    // Read-first memory: a same-line write wins and the read retries next cycle.
    assign collision    = wr_accept &
                          (rd_req_addr[ADDR_W+BANK_SEL_W-1:BANK_SEL_W] == wr_req_addr);
    assign rd_req_ready = run_ok & (used < CREDITS) & ~collision;
    assign rd_accept    = rd_req_valid & rd_req_ready;

    assign bram_en      = active_reg;
    assign bram_we      = (state_reg == CLEAR) | wr_accept;
    assign bram_r_addr  = rd_accept ? rd_req_addr : '0;
    assign bram_w_addr  = (state_reg == CLEAR) ? line_cnt_reg[ADDR_W-1:0] :
                          wr_accept            ? wr_req_addr              : '0;
    assign bram_data_in = (state_reg == CLEAR) ? {BANKS{CLEAR_VAL}} :
                          wr_accept            ? wr_req_data        : '0;

    assign clr_busy      = (state_reg != RUN);
    assign clr_done      = clr_done_reg;
    assign rd_resp_valid = ~fifo_empty;
    assign resp_pop      = rd_resp_valid & rd_resp_ready;

    always_comb begin
        state_next    = state_reg;
        line_cnt_next = line_cnt_reg;
        clr_done_next = 1'b0;
        case (state_reg)
            RUN: begin
                if (active_reg && clr_start) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                line_cnt_next = '0;
                if (vld_reg == 2'b00) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                line_cnt_next = line_cnt_reg + 1'b1;
                if (line_cnt_reg == LAST_LINE) begin
                    state_next    = RUN;
                    clr_done_next = 1'b1;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= RUN;
            line_cnt_reg <= '0;
            clr_done_reg <= 1'b0;
            active_reg   <= 1'b0;
            vld_reg      <= 2'b00;
        end else begin
            state_reg    <= state_next;
            line_cnt_reg <= line_cnt_next;
            clr_done_reg <= clr_done_next;
            active_reg   <= 1'b1;
            vld_reg      <= {vld_reg[0], rd_accept};
        end
    end

    mbb_resp_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (vld_reg[1]),
        .push_data (bram_data_out),
        .pop       (resp_pop),
        .head      (rd_resp_data),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_multi_bank_bram_ctrl.sv
// Directed bench for multi_bank_bram_ctrl with a read-first, 2-cycle-latency
// BRAM model and a 16-line geometry.
module tb_multi_bank_bram_ctrl;

    localparam int ADDR_W = 4;
    localparam int RA_W   = ADDR_W + 6;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            clr_start;
    logic            clr_busy;
    logic            clr_done;
    logic            rd_req_valid;
    logic            rd_req_ready;
    logic [RA_W-1:0] rd_req_addr;
    logic            rd_resp_valid;
    logic            rd_resp_ready;
    logic [7:0]      rd_resp_data;
    logic            wr_req_valid;
    logic            wr_req_ready;
    logic [ADDR_W-1:0] wr_req_addr;
    logic [511:0]    wr_req_data;
    logic [511:0]    bram_data_in;
    logic [RA_W-1:0] bram_r_addr;
    logic [ADDR_W-1:0] bram_w_addr;
    logic            bram_we;
    logic            bram_en;
    logic [7:0]      bram_data_out;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int         acc_q[$];
    int         wacc_q[$];
    int         we_q[$];
    int         rcyc_q[$];
    logic [7:0] resp_q[$];

    logic [511:0] mem [16];
    logic [7:0]   pipe1;
    logic [7:0]   pipe2;

    multi_bank_bram_ctrl #(
        .DATA_W     (8),
        .ADDR_W     (ADDR_W),
        .RESP_DEPTH (4),
        .CLEAR_VAL  (8'hFF)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clr_start     (clr_start),
        .clr_busy      (clr_busy),
        .clr_done      (clr_done),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_req_addr   (rd_req_addr),
        .rd_resp_valid (rd_resp_valid),
        .rd_resp_ready (rd_resp_ready),
        .rd_resp_data  (rd_resp_data),
        .wr_req_valid  (wr_req_valid),
        .wr_req_ready  (wr_req_ready),
        .wr_req_addr   (wr_req_addr),
        .wr_req_data   (wr_req_data),
        .bram_data_in  (bram_data_in),
        .bram_r_addr   (bram_r_addr),
        .bram_w_addr   (bram_w_addr),
        .bram_we       (bram_we),
        .bram_en       (bram_en),
        .bram_data_out (bram_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Read-first BRAM with a two-register read pipeline.
    assign bram_data_out = pipe2;
    always @(posedge clk) begin
        if (bram_en) begin
            pipe1 <= mem[bram_r_addr[RA_W-1:6]][int'(bram_r_addr[5:0])*8 +: 8];
            pipe2 <= pipe1;
            if (bram_we) mem[bram_w_addr] <= bram_data_in;
        end
    end

    // Handshake log, sampled mid-cycle.
    always @(negedge clk) begin
        if (rd_req_valid && rd_req_ready) acc_q.push_back(cyc);
        if (wr_req_valid && wr_req_ready) wacc_q.push_back(cyc);
        if (bram_we) we_q.push_back(cyc);
        if (rd_resp_valid && rd_resp_ready) begin
            resp_q.push_back(rd_resp_data);
            rcyc_q.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input logic [RA_W-1:0] a);
        logic ok;
        ok = 1'b0;
        rd_req_valid = 1'b1;
        rd_req_addr  = a;
        for (int k = 0; k < 20 && !ok; k++) begin
            #1;
            ok = rd_req_ready;
            @(posedge clk);
            #1;
        end
        chk("rd_accept", ok, 1);
        rd_req_valid = 1'b0;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [511:0] d);
        wr_req_valid = 1'b1;
        wr_req_addr  = a;
        wr_req_data  = d;
        #1;
        chk("wr_ready", wr_req_ready, 1);
        @(posedge clk);
        #1;
        wr_req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int target);
        for (int k = 0; k < 200 && resp_q.size() < target; k++) @(posedge clk);
        chk("resp_count", resp_q.size() >= target, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wcnt, dcnt, a0, r0, w0, wa0, issued;
        logic [511:0] d;
        logic found;

        rst_n = 1'b0; clr_start = 1'b0; rd_req_valid = 1'b0; rd_req_addr = '0;
        rd_resp_ready = 1'b0; wr_req_valid = 1'b0; wr_req_addr = '0; wr_req_data = '0;

        // Reset state
        @(posedge clk); #2;
        chk("rst_rd_ready", rd_req_ready, 0);
        chk("rst_wr_ready", wr_req_ready, 0);
        chk("rst_resp_valid", rd_resp_valid, 0);
        chk("rst_we", bram_we, 0);
        chk("rst_en", bram_en, 0);
        chk("rst_busy", clr_busy, 0);
        chk("rst_done", clr_done, 0);
        chk("rst_r_addr", bram_r_addr, 0);
        chk("rst_w_addr", bram_w_addr, 0);
        chk("rst_data_in", bram_data_in == '0, 1);
        chk("rst_resp_data", rd_resp_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #2;
        chk("run_rd_ready", rd_req_ready, 1);
        chk("run_wr_ready", wr_req_ready, 1);
        chk("run_en", bram_en, 1);
        @(posedge clk); #1;

        // Clear sweep over 16 lines
        clr_start = 1'b1;
        @(posedge clk); #1;
        clr_start = 1'b0;
        #1;
        chk("clr_busy_rise", clr_busy, 1);
        chk("clr_rd_ready", rd_req_ready, 0);
        chk("clr_wr_ready", wr_req_ready, 0);
        wcnt = 0; dcnt = 0;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #2;
            if (bram_we) begin
                chk("clr_line", bram_w_addr, wcnt);
                chk("clr_data", bram_data_in == {64{8'hFF}}, 1);
                wcnt++;
            end
            if (clr_done) begin
                chk("done_busy_low", clr_busy, 0);
                dcnt++;
            end
        end
        chk("clr_writes", wcnt, 16);
        chk("clr_done_pulses", dcnt, 1);
        @(posedge clk); #1;

        // Reads after clear return CLEAR_VAL
        rd_resp_ready = 1'b1;
        r0 = resp_q.size();
        do_read(10'h000);
        do_read(10'h3FF);
        do_read(10'h155);
        wait_resp(r0 + 3);
        chk("clr_rd_000", resp_q[r0], 8'hFF);
        chk("clr_rd_3ff", resp_q[r0+1], 8'hFF);
        chk("clr_rd_155", resp_q[r0+2], 8'hFF);

        // Line 3 holds byte k = k; stream all 64 banks back to back
        for (int k = 0; k < 64; k++) d[k*8 +: 8] = 8'(k);
        do_write(4'd3, d);
        a0 = acc_q.size(); r0 = resp_q.size();
        for (int i = 0; i < 64; i++) do_read(10'(10'h0C0 + i));
        wait_resp(r0 + 64);
        for (int i = 0; i < 64; i++) chk("stream_data", resp_q[r0+i], 8'(i));
        chk("stream_latency", rcyc_q[r0] - acc_q[a0], 3);
        chk("stream_acc_rate", acc_q[a0+63] - acc_q[a0], 63);
        chk("stream_resp_rate", rcyc_q[r0+63] - rcyc_q[r0], 63);

        // Same-line write and read: write wins, read retries and sees new data
        d = {64{8'h5A}};
        d[7*8 +: 8] = 8'hA5;
        a0 = acc_q.size(); r0 = resp_q.size(); wa0 = wacc_q.size();
        wr_req_valid = 1'b1; wr_req_addr = 4'd5; wr_req_data = d;
        rd_req_valid = 1'b1; rd_req_addr = 10'h147;
        #1;
        chk("coll_rd_stall", rd_req_ready, 0);
        chk("coll_wr_ready", wr_req_ready, 1);
        chk("coll_we", bram_we, 1);
        chk("coll_w_addr", bram_w_addr, 5);
        @(posedge clk); #1;
        wr_req_valid = 1'b0;
        #1;
        chk("coll_rd_retry", rd_req_ready, 1);
        @(posedge clk); #1;
        rd_req_valid = 1'b0;
        wait_resp(r0 + 1);
        chk("coll_stall_len", acc_q[a0] - wacc_q[wa0], 1);
        chk("coll_new_data", resp_q[r0], 8'hA5);

        // Backpressure: only RESP_DEPTH reads accepted while the consumer stalls
        rd_resp_ready = 1'b0;
        a0 = acc_q.size(); r0 = resp_q.size();
        issued = 0;
        rd_req_valid = 1'b1; rd_req_addr = 10'h0CA;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (rd_req_ready) issued++;
            @(posedge clk); #1;
            rd_req_valid = (issued < 8);
            rd_req_addr  = 10'(10'h0CA + issued);
        end
        #1;
        chk("bp_accepted", acc_q.size() - a0, 4);
        chk("bp_rd_ready", rd_req_ready, 0);
        chk("bp_resp_valid", rd_resp_valid, 1);
        chk("bp_no_pop", resp_q.size() - r0, 0);
        @(posedge clk); #1;
        rd_resp_ready = 1'b1;
        for (int c = 0; c < 40 && issued < 8; c++) begin
            #1;
            if (rd_req_ready) issued++;
            @(posedge clk); #1;
            rd_req_valid = (issued < 8);
            rd_req_addr  = 10'(10'h0CA + issued);
        end
        rd_req_valid = 1'b0;
        wait_resp(r0 + 8);
        chk("bp_total_acc", acc_q.size() - a0, 8);
        for (int i = 0; i < 8; i++) chk("bp_order", resp_q[r0+i], 8'(10 + i));

        // Clear requested with two reads in flight
        a0 = acc_q.size(); r0 = resp_q.size(); w0 = we_q.size();
        rd_req_valid = 1'b1; rd_req_addr = 10'h0E0;
        #1;
        chk("cif_rd0_ready", rd_req_ready, 1);
        @(posedge clk); #1;
        rd_req_addr = 10'h0E1; clr_start = 1'b1;
        #1;
        chk("cif_rd1_ready", rd_req_ready, 1);
        @(posedge clk); #1;
        clr_start = 1'b0;
        rd_req_addr = 10'h000;
        wr_req_valid = 1'b1; wr_req_addr = 4'd2; wr_req_data = '0;
        #1;
        chk("cif_busy", clr_busy, 1);
        chk("cif_rd_blocked", rd_req_ready, 0);
        chk("cif_wr_blocked", wr_req_ready, 0);
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            @(posedge clk); #2;
            found = bram_we && (bram_w_addr == 4'd7);
        end
        chk("cif_line7_seen", found, 1);
        chk("cif_accepts", acc_q.size() - a0, 2);
        chk("cif_resps", resp_q.size() - r0, 2);
        chk("cif_resp0", resp_q[r0], 8'h20);
        chk("cif_resp1", resp_q[r0+1], 8'h21);
        chk("cif_first_we", we_q[w0] - acc_q[a0+1], 4);

        // Asynchronous reset in the middle of the sweep
        rst_n = 1'b0;
        #1;
        chk("ar_rd_ready", rd_req_ready, 0);
        chk("ar_wr_ready", wr_req_ready, 0);
        chk("ar_we", bram_we, 0);
        chk("ar_en", bram_en, 0);
        chk("ar_busy", clr_busy, 0);
        chk("ar_done", clr_done, 0);
        chk("ar_w_addr", bram_w_addr, 0);
        chk("ar_r_addr", bram_r_addr, 0);
        chk("ar_data_in", bram_data_in == '0, 1);
        chk("ar_resp_valid", rd_resp_valid, 0);
        rd_req_valid = 1'b0; wr_req_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #2;
        chk("post_rd_ready", rd_req_ready, 1);
        chk("post_wr_ready", wr_req_ready, 1);
        chk("post_busy", clr_busy, 0);
        chk("post_en", bram_en, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
